// File: rtl/ahb_slave_i2c_fe_pkg.sv
// Shared encodings, register offsets and FSM state type for the AHB-to-I2C front end.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_RXDATA = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic htrans_active(input logic [1:0] trans);
    logic act;
    act = 1'b0;
    case (trans)
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      default:                   act = 1'b0;
    endcase
    return act;
  endfunction

  function automatic logic is_legal(input logic [2:0] size, input logic [3:0] addr,
                                    input logic write);
    return (size == HSIZE_WORD) && (addr[1:0] == 2'b00) &&
           !(write && ((addr == REG_STATUS) || (addr == REG_RXDATA)));
  endfunction

endpackage

// File: rtl/ahb_slave_i2c_fe_if.sv
// AHB-Lite slave-side bus bundle for the I2C front end.
interface ahb_slave_i2c_fe_if #(
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [31:0]       haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready_in;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport slave (
    input  hsel, haddr, hwrite, htrans, hsize, hburst, hwdata, hready_in,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, hwrite, htrans, hsize, hburst, hwdata, hready_in,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_i2c_fe_fifo.sv
// TX word FIFO; power-of-two depth so pointers wrap by natural overflow.
module ahb_slv_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ahb_slave_i2c_fe.sv
// AHB-Lite register front end for an I2C engine: TX FIFO, RX byte, CTRL and STATUS.
// Define AHB_SLV_ERR_RESP_EN to answer illegal transfers with a two-cycle ERROR.
//   state | meaning
//   IDLE  | no data phase pending
//   DATA  | data phase of a captured transfer
//   WAIT  | TXDATA write stalled on a full FIFO
//   ERR1  | first ERROR cycle (hreadyout low)
//   ERR2  | second ERROR cycle (hreadyout high)
module ahb_slave_i2c_fe
  import ahb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              Hclk,
  input  logic              Hreset,
  ahb_slave_i2c_fe_if.slave bus,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_byte,
  input  logic              rx_load,
  output logic [7:0]        i2c_ctrl
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [3:0]        addr_q, addr_d;
  logic              write_q, write_d, legal_q, legal_d;
  logic [7:0]        ctrl_q, rx_reg_q;
  logic              rx_valid_q;
  logic              push, ctrl_we, rx_rd, capture, phase_done, is_tx;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        count_w;
  logic [2:0]        count_sat;
  logic [DATA_W-1:0] reg_rdata;
  logic              unused_bits;

  assign unused_bits = ^{bus.haddr[31:4], bus.hburst};
  assign capture     = bus.hsel & bus.hready_in & htrans_active(bus.htrans);
  assign count_w     = 8'(fifo_count);
  assign count_sat   = (count_w > 8'd7) ? 3'd7 : count_w[2:0];
  assign is_tx       = legal_q & write_q & (addr_q == REG_TXDATA);
  assign tx_valid    = ~fifo_empty;
  assign i2c_ctrl    = ctrl_q;

  always_comb begin
    reg_rdata = '0;
    case (addr_q)
      REG_STATUS: reg_rdata = DATA_W'({26'b0, rx_valid_q, fifo_empty, fifo_full, count_sat});
      REG_RXDATA: reg_rdata = DATA_W'({24'b0, rx_reg_q});
      REG_CTRL:   reg_rdata = DATA_W'({24'b0, ctrl_q});
      default:    reg_rdata = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    legal_d       = legal_q;
    push          = 1'b0;
    ctrl_we       = 1'b0;
    rx_rd         = 1'b0;
    phase_done    = 1'b0;
    bus.hreadyout = 1'b1;
    bus.hresp     = HRESP_OKAY;
    bus.hrdata    = '0;
    case (state_q)
      ST_IDLE: phase_done = 1'b1;
      ST_DATA: begin
        if (is_tx && fifo_full) begin
          bus.hreadyout = 1'b0;
          state_d       = ST_WAIT;
        end else begin
          phase_done = 1'b1;
          push       = is_tx;
          ctrl_we    = legal_q & write_q & (addr_q == REG_CTRL);
          rx_rd      = legal_q & ~write_q & (addr_q == REG_RXDATA);
          if (legal_q && !write_q) bus.hrdata = reg_rdata;
        end
      end
      ST_WAIT: begin
        // full is registered, so a pop this cycle only frees us next cycle
        if (fifo_full) begin
          bus.hreadyout = 1'b0;
        end else begin
          push       = 1'b1;
          phase_done = 1'b1;
        end
      end
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = HRESP_ERROR;
        state_d       = ST_ERR2;
      end
      ST_ERR2: begin
        bus.hresp = HRESP_ERROR;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (phase_done) begin
      state_d = ST_IDLE;
      if (capture) begin
        addr_d  = bus.haddr[3:0];
        write_d = bus.hwrite;
        legal_d = is_legal(bus.hsize, bus.haddr[3:0], bus.hwrite);
`ifdef AHB_SLV_ERR_RESP_EN
        state_d = legal_d ? ST_DATA : ST_ERR1;
`else
        state_d = ST_DATA;
`endif
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      legal_q    <= 1'b0;
      ctrl_q     <= '0;
      rx_reg_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      legal_q <= legal_d;
      if (ctrl_we) ctrl_q <= bus.hwdata[7:0];
      // a fresh byte beats the read-clear
      if (rx_load) begin
        rx_reg_q   <= rx_byte;
        rx_valid_q <= 1'b1;
      end else if (rx_rd) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  ahb_slv_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (Hclk),
    .rst   (Hreset),
    .push  (push),
    .pop   (tx_ready),
    .wdata (bus.hwdata),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_ahb_slave_i2c_fe.sv
// Directed bench for ahb_slave_i2c_fe: vector table of single transfers plus multi-cycle sequences.
module tb_ahb_slave_i2c_fe;
  import ahb_pkg::*;

`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_load;
  logic [7:0]  i2c_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 Hclk = ~Hclk;

  ahb_slave_i2c_fe_if #(.DATA_W(32)) bus ();
  assign bus.hready_in = bus.hreadyout;

  ahb_slave_i2c_fe #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_byte  (rx_byte),
    .rx_load  (rx_load),
    .i2c_ctrl (i2c_ctrl)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_resp;
    int          exp_waits;
    logic [7:0]  exp_ctrl;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string name, input logic wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata,
                              input logic [31:0] er, input logic eresp, input int ew,
                              input logic [7:0] ec);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = er; v.exp_resp = eresp; v.exp_waits = ew; v.exp_ctrl = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle_bus();
    bus.hsel   = 1'b0;
    bus.haddr  = '0;
    bus.hwrite = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hsize  = HSIZE_WORD;
    bus.hburst = 3'b000;
    bus.hwdata = '0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [1:0] trans);
    bus.hsel   = 1'b1;
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.htrans = trans;
    bus.hsize  = size;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic resp, output int waits);
    addr_phase(wr, addr, size, HTRANS_NONSEQ);
    step();
    idle_bus();
    bus.hwdata = wdata;
    waits = 0;
    resp  = 1'b0;
    rdata = '0;
    forever begin
      @(negedge Hclk);
      if (bus.hresp) resp = 1'b1;
      rdata = bus.hrdata;
      if (bus.hreadyout) break;
      waits++;
      if (waits > 50) begin
        checks++;
        errors++;
        $display("FAIL xfer_timeout: addr %h still stalled after %0d cycles", addr, waits);
        break;
      end
      step();
    end
    step();
    bus.hwdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        rsp;
    int          w;

    vecs[0]  = mk("w_ctrl_a5",      1, 32'h0C, HSIZE_WORD, 32'hA5,       32'h0,  0, 0, 8'hA5);
    vecs[1]  = mk("r_ctrl",         0, 32'h0C, HSIZE_WORD, 32'h0,        32'hA5, 0, 0, 8'hA5);
    vecs[2]  = mk("r_status_empty", 0, 32'h04, HSIZE_WORD, 32'h0,        32'h10, 0, 0, 8'hA5);
    vecs[3]  = mk("w_txdata",       1, 32'h00, HSIZE_WORD, 32'hDEADBEEF, 32'h0,  0, 0, 8'hA5);
    vecs[4]  = mk("r_status_one",   0, 32'h04, HSIZE_WORD, 32'h0,        32'h01, 0, 0, 8'hA5);
    vecs[5]  = mk("r_rxdata_none",  0, 32'h08, HSIZE_WORD, 32'h0,        32'h0,  0, 0, 8'hA5);
    vecs[6]  = mk("w_ctrl_byte",    1, 32'h0C, 3'b000,     32'h5A,       32'h0,  ERR_EN, int'(ERR_EN), 8'hA5);
    vecs[7]  = mk("w_ctrl_misalgn", 1, 32'h0D, HSIZE_WORD, 32'h11,       32'h0,  ERR_EN, int'(ERR_EN), 8'hA5);
    vecs[8]  = mk("w_status_ro",    1, 32'h04, HSIZE_WORD, 32'hFF,       32'h0,  ERR_EN, int'(ERR_EN), 8'hA5);
    vecs[9]  = mk("r_misalgn",      0, 32'h06, HSIZE_WORD, 32'h0,        32'h0,  ERR_EN, int'(ERR_EN), 8'hA5);
    vecs[10] = mk("r_status_still", 0, 32'h04, HSIZE_WORD, 32'h0,        32'h01, 0, 0, 8'hA5);
    vecs[11] = mk("w_ctrl_03",      1, 32'h0C, HSIZE_WORD, 32'h03,       32'h0,  0, 0, 8'h03);
    vecs[12] = mk("r_txdata",       0, 32'h00, HSIZE_WORD, 32'h0,        32'h0,  0, 0, 8'h03);

    idle_bus();
    tx_ready = 1'b0;
    rx_load  = 1'b0;
    rx_byte  = '0;
    Hreset   = 1'b1;
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_hreadyout", 32'(bus.hreadyout), 32'h1);
    chk("rst_hresp",     32'(bus.hresp),     32'h0);
    chk("rst_hrdata",    bus.hrdata,         32'h0);
    chk("rst_tx_valid",  32'(tx_valid),      32'h0);
    chk("rst_i2c_ctrl",  32'(i2c_ctrl),      32'h0);
    step();
    Hreset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rsp, w);
      chk({vecs[i].name, "_rdata"}, rd,             vecs[i].exp_rdata);
      chk({vecs[i].name, "_resp"},  32'(rsp),       32'(vecs[i].exp_resp));
      chk({vecs[i].name, "_waits"}, 32'(w),         32'(vecs[i].exp_waits));
      chk({vecs[i].name, "_ctrl"},  32'(i2c_ctrl),  32'(vecs[i].exp_ctrl));
    end

    // RX byte capture, read-clear, and load colliding with a read
    rx_load = 1'b1; rx_byte = 8'h3C;
    step();
    rx_load = 1'b0;
    xfer(0, 32'h08, HSIZE_WORD, 0, rd, rsp, w);
    chk("rx_read_3c", rd, 32'h3C);
    xfer(0, 32'h04, HSIZE_WORD, 0, rd, rsp, w);
    chk("rx_valid_cleared", rd & 32'h20, 32'h0);
    rx_load = 1'b1; rx_byte = 8'h11;
    step();
    rx_load = 1'b0;
    addr_phase(0, 32'h08, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    idle_bus();
    rx_load = 1'b1; rx_byte = 8'h77;
    @(negedge Hclk);
    chk("rx_collide_rdata", bus.hrdata, 32'h11);
    step();
    rx_load = 1'b0;
    xfer(0, 32'h04, HSIZE_WORD, 0, rd, rsp, w);
    chk("rx_collide_valid", rd & 32'h20, 32'h20);
    xfer(0, 32'h08, HSIZE_WORD, 0, rd, rsp, w);
    chk("rx_collide_newbyte", rd, 32'h77);

    // drain the single DEADBEEF entry
    @(negedge Hclk);
    chk("head_deadbeef", tx_data, 32'hDEADBEEF);
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    @(negedge Hclk);
    chk("drained_valid", 32'(tx_valid), 32'h0);
    step();

    // fill to full, stall the fifth write, release it with one pop
    for (int k = 0; k < 4; k++) begin
      xfer(1, 32'h00, HSIZE_WORD, 32'h101 + 32'(k), rd, rsp, w);
      chk("fill_waits", 32'(w), 32'h0);
    end
    addr_phase(1, 32'h00, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    idle_bus();
    bus.hwdata = 32'h105;
    @(negedge Hclk);
    chk("stall_data", 32'(bus.hreadyout), 32'h0);
    step();
    @(negedge Hclk);
    chk("stall_wait", 32'(bus.hreadyout), 32'h0);
    step();
    tx_ready = 1'b1;
    @(negedge Hclk);
    chk("stall_pop_cycle", 32'(bus.hreadyout), 32'h0);
    step();
    tx_ready = 1'b0;
    @(negedge Hclk);
    chk("stall_release", 32'(bus.hreadyout), 32'h1);
    chk("head_after_pop", tx_data, 32'h102);
    step();
    bus.hwdata = '0;
    xfer(0, 32'h04, HSIZE_WORD, 0, rd, rsp, w);
    chk("status_full", rd, 32'h0C);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      chk("drain_order", tx_data, 32'h102 + 32'(k));
      step();
    end
    tx_ready = 1'b0;
    @(negedge Hclk);
    chk("drain_empty", 32'(tx_valid), 32'h0);
    step();

    // reset while stalled in WAIT
    for (int k = 0; k < 4; k++) xfer(1, 32'h00, HSIZE_WORD, 32'h200 + 32'(k), rd, rsp, w);
    addr_phase(1, 32'h00, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    idle_bus();
    bus.hwdata = 32'h204;
    @(negedge Hclk);
    chk("rstwait_stall", 32'(bus.hreadyout), 32'h0);
    step();
    Hreset = 1'b1;
    idle_bus();
    step();
    @(negedge Hclk);
    chk("rstwait_hreadyout", 32'(bus.hreadyout), 32'h1);
    chk("rstwait_tx_valid",  32'(tx_valid),      32'h0);
    step();
    Hreset = 1'b0;
    xfer(0, 32'h04, HSIZE_WORD, 0, rd, rsp, w);
    chk("rstwait_status", rd, 32'h10);
    chk("rstwait_ctrl", 32'(i2c_ctrl), 32'h0);

    // back-to-back NONSEQ/SEQ writes streaming out
    tx_ready = 1'b1;
    addr_phase(1, 32'h00, HSIZE_WORD, HTRANS_NONSEQ);
    step();
    bus.htrans = HTRANS_SEQ;
    bus.hwdata = 32'h11;
    @(negedge Hclk);
    chk("b2b_ready_0", 32'(bus.hreadyout), 32'h1);
    step();
    bus.hwdata = 32'h22;
    @(negedge Hclk);
    chk("b2b_ready_1", 32'(bus.hreadyout), 32'h1);
    chk("b2b_tx_11", tx_valid ? tx_data : 32'hFFFF_FFFF, 32'h11);
    step();
    idle_bus();
    bus.hwdata = 32'h33;
    @(negedge Hclk);
    chk("b2b_ready_2", 32'(bus.hreadyout), 32'h1);
    chk("b2b_tx_22", tx_valid ? tx_data : 32'hFFFF_FFFF, 32'h22);
    step();
    bus.hwdata = '0;
    @(negedge Hclk);
    chk("b2b_tx_33", tx_valid ? tx_data : 32'hFFFF_FFFF, 32'h33);
    step();
    tx_ready = 1'b0;
    @(negedge Hclk);
    chk("b2b_empty", 32'(tx_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
